ball_sprite_loader: RTL and testbench
=====================================

BALL_SPRITE_LOADER -- requirements
Module: ball_sprite_loader

Interface
REQ-001 Parameter: COMMIT_ON_VSYNC, default 1; 1 = commit the loaded sprite on the next vsync_tick, 0 = commit on the cycle after the last row is accepted.
REQ-002 Port: clk  input  1  sole clock, rising edge.
REQ-003 Port: reset_n  input  1  reset, asynchronous assert, active-low.
REQ-004 Port: wr_valid  input  1  source presents a sprite row.
REQ-005 Port: wr_ready  output  1  block can accept a row.
REQ-006 Port: wr_data  input  8  row bitmap; bit 7 = leftmost pixel.
REQ-007 Port: wr_last  input  1  marks the final (8th) row of a sprite.
REQ-008 Port: vsync_tick  input  1  one-cycle frame-boundary pulse.
REQ-009 Port: rd_addr  input  3  renderer row select.
REQ-010 Port: rd_data  output  8  active bitmap row at rd_addr.
REQ-011 Port: busy  output  1  high in LOAD or PEND.
REQ-012 Port: err  output  1  one-cycle pulse on a framing error.

Function
REQ-013 Storage: shadow buffer, 8x8 bits, written by the loader; active buffer, 8x8 bits, read by the renderer.
REQ-014 rd_data shall be a combinational read of active[rd_addr], with zero latency.
REQ-015 Transfer: a row is accepted on a clk edge where wr_valid && wr_ready are both high.
REQ-016 FSM states: IDLE, LOAD, PEND.
REQ-017 wr_ready = 1 in IDLE and LOAD; wr_ready = 0 in PEND.
REQ-018 In IDLE, an accepted row writes shadow[0], sets row_cnt to 1 and moves the FSM to LOAD.
REQ-019 In LOAD, an accepted row writes shadow[row_cnt] and increments row_cnt.
REQ-020 Normal completion: the row accepted at row_cnt = 7 with wr_last = 1 completes the sprite; the FSM moves to PEND.
REQ-021 Early last: wr_last = 1 on an accepted row with row_cnt < 7 shall pulse err, discard the shadow contents, and return the FSM to IDLE.
REQ-022 Missing last: the row accepted at row_cnt = 7 with wr_last = 0 shall pulse err, discard, and return the FSM to IDLE.
REQ-023 On any err, the active buffer is unchanged.
REQ-024 PEND with COMMIT_ON_VSYNC = 1: on vsync_tick, copy shadow to active in one cycle, then move to IDLE.
REQ-025 PEND with COMMIT_ON_VSYNC = 0: copy shadow to active on the first PEND cycle, then move to IDLE.
REQ-026 The active buffer changes only on a commit edge, so the renderer never sees a partial sprite.
REQ-027 A vsync_tick coincident with the completing row shall not commit; the commit waits for the next vsync_tick.
REQ-028 vsync_tick in IDLE or LOAD shall have no effect.
REQ-029 row_cnt is 3 bits; it cannot wrap, because row 7 always exits LOAD.
REQ-030 busy = (state != IDLE).

Reset
REQ-031 While reset_n = 0: state = IDLE, row_cnt = 0, err = 0, wr_ready = 1, busy = 0, shadow cleared to all 0.
REQ-032 While reset_n = 0, active is loaded with the round ball rows 3C,7E,FF,FF,FF,FF,7E,3C (hex, row 0 first).
REQ-033 Reset asserted mid-LOAD or mid-PEND shall abandon the transfer and restore the REQ-032 pattern.

Structure
REQ-034 A shared package shall hold the state encoding, the ROWS = 8 constant, and the default ball pattern constant.
REQ-035 One sub-module, sprite_buf, shall implement an 8x8 register array with a write port, a bulk-load port and a combinational read port, instanced twice (shadow, active).

Verification
REQ-036 Scenario: after reset, sweep rd_addr 0..7 -> rd_data = 3C,7E,FF,FF,FF,FF,7E,3C.
REQ-037 Scenario: load rows 81,42,24,18,18,24,42,81 with wr_last on row 7, then vsync_tick -> rd_data unchanged before the tick; rd_addr 3 reads 18 after the tick; busy low after the commit.
REQ-038 Scenario: wr_last on the 4th row -> err pulses one cycle, FSM returns to IDLE, active buffer still 3C.. pattern.
REQ-039 Scenario: 8 rows without wr_last -> err pulses on the 8th accept; active buffer unchanged.
REQ-040 Scenario: vsync_tick in the same cycle as the completing row -> no commit; commit occurs on the next vsync_tick; wr_ready = 0 throughout PEND.
REQ-041 Scenario: reset_n pulsed low after 5 rows -> IDLE, active = ball pattern; a following full load commits normally.

Source files
------------

// File: rtl/ball_sprite_loader_pkg.sv
// ball_sprite_loader_pkg: shared FSM encoding, geometry and default ball sprite.
package ball_sprite_loader_pkg;
  localparam int ROWS = 8;
  // Row r of a flattened 8x8 bitmap lives in bits [8r +: 8]; bit 7 is the leftmost pixel.
  localparam logic [63:0] BALL = 64'h3C7E_FFFF_FFFF_7E3C;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PEND = 2'd2
  } state_t;
  function automatic logic [7:0] row_of(input logic [63:0] rows, input logic [2:0] r);
    return rows[{r, 3'b000} +: 8];
  endfunction
endpackage

// File: rtl/ball_sprite_loader_sprite_buf.sv
// sprite_buf: 8x8 bit register array with row write, bulk load and combinational row read.
module sprite_buf
  import ball_sprite_loader_pkg::*;
#(
  parameter logic [63:0] INIT = '0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        we_i,
  input  logic [2:0]  waddr_i,
  input  logic [7:0]  wdata_i,
  input  logic        load_i,
  input  logic [63:0] load_data_i,
  input  logic [2:0]  raddr_i,
  output logic [7:0]  rdata_o,
  output logic [63:0] rows_o
);
  logic [63:0] mem_q, mem_d;
  always_comb begin
    mem_d = load_i ? load_data_i : mem_q;
    if (we_i && !load_i) mem_d[{waddr_i, 3'b000} +: 8] = wdata_i;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) mem_q <= INIT;
    else          mem_q <= mem_d;
  end
  assign rdata_o = row_of(mem_q, raddr_i);
  assign rows_o  = mem_q;
endmodule

// File: rtl/ball_sprite_loader.sv
// ball_sprite_loader: double-buffered 8x8 sprite loader; rows fill a shadow buffer
// which is copied whole into the renderer-visible active buffer on commit.
module ball_sprite_loader
  import ball_sprite_loader_pkg::*;
#(
  parameter bit COMMIT_ON_VSYNC = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [7:0] wr_data,
  input  logic       wr_last,
  input  logic       vsync_tick,
  input  logic [2:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       busy,
  output logic       err
);
  localparam logic [2:0] LAST_ROW = 3'(ROWS - 1);
  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        accept, sh_we, sh_clr, commit;
  logic [63:0] sh_rows;
  logic [7:0]  sh_rd_unused;
  logic [63:0] act_rows_unused;
  assign accept   = wr_valid && wr_ready;
  assign wr_ready = state_q != PEND;
  assign busy     = state_q != IDLE;
  assign err      = err_q;
  // Framing is wrong exactly when wr_last disagrees with "this is row 7".
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    sh_we   = 1'b0;
    sh_clr  = 1'b0;
    commit  = 1'b0;
    case (state_q)
      IDLE, LOAD: if (accept) begin
        sh_we   = 1'b1;
        cnt_d   = cnt_q + 3'd1;
        state_d = LOAD;
        if (wr_last != (cnt_q == LAST_ROW)) begin
          err_d   = 1'b1;
          sh_clr  = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else if (wr_last) begin
          cnt_d   = '0;
          state_d = PEND;
        end
      end
      PEND: if (!COMMIT_ON_VSYNC || vsync_tick) begin
        commit  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end
  sprite_buf #(.INIT('0)) u_shadow (
    .clk         (clk),
    .reset_n     (reset_n),
    .we_i        (sh_we),
    .waddr_i     (cnt_q),
    .wdata_i     (wr_data),
    .load_i      (sh_clr),
    .load_data_i (64'd0),
    .raddr_i     (cnt_q),
    .rdata_o     (sh_rd_unused),
    .rows_o      (sh_rows)
  );
  sprite_buf #(.INIT(BALL)) u_active (
    .clk         (clk),
    .reset_n     (reset_n),
    .we_i        (1'b0),
    .waddr_i     (3'd0),
    .wdata_i     (8'd0),
    .load_i      (commit),
    .load_data_i (sh_rows),
    .raddr_i     (rd_addr),
    .rdata_o     (rd_data),
    .rows_o      (act_rows_unused)
  );
endmodule

// File: tb/tb_ball_sprite_loader.sv
// tb_ball_sprite_loader: directed scenarios checked against a row-queue model every cycle.
module tb_ball_sprite_loader;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [7:0] wr_data = 8'h00;
  logic       wr_last = 1'b0;
  logic       vsync_tick = 1'b0;
  logic [2:0] rd_addr = 3'd0;
  logic [7:0] rd_data;
  logic       busy;
  logic       err;
  int n_run = 0;
  int n_fail = 0;
  bit started = 1'b0;

  ball_sprite_loader dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_data    (wr_data),
    .wr_last    (wr_last),
    .vsync_tick (vsync_tick),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  logic [7:0] ball [8] = '{8'h3C, 8'h7E, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h7E, 8'h3C};

  // Model: rows collected so far, a pending sprite, and what the renderer sees.
  logic [7:0] m_active [8];
  logic [7:0] m_shadow [8];
  logic [7:0] m_rows [$];
  bit m_pend;
  bit m_err;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_active = ball;
      m_rows.delete();
      m_pend = 1'b0;
      m_err = 1'b0;
    end else begin
      m_err = 1'b0;
      if (m_pend) begin
        if (vsync_tick) begin
          m_active = m_shadow;
          m_pend = 1'b0;
        end
      end else if (wr_valid) begin
        m_rows.push_back(wr_data);
        if (wr_last && m_rows.size() == 8) begin
          for (int i = 0; i < 8; i++) m_shadow[i] = m_rows[i];
          m_rows.delete();
          m_pend = 1'b1;
        end else if (wr_last || m_rows.size() == 8) begin
          m_rows.delete();
          m_err = 1'b1;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      chk("model_rd_data", rd_data, m_active[rd_addr]);
      chk("model_wr_ready", {7'd0, wr_ready}, {7'd0, !m_pend});
      chk("model_busy", {7'd0, busy}, {7'd0, (m_rows.size() != 0) || m_pend});
      chk("model_err", {7'd0, err}, {7'd0, m_err});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic last, input logic vs);
    wr_valid = 1'b1;
    wr_data = d;
    wr_last = last;
    vsync_tick = vs;
    tick();
    wr_valid = 1'b0;
    wr_last = 1'b0;
    vsync_tick = 1'b0;
  endtask

  task automatic vsync();
    vsync_tick = 1'b1;
    tick();
    vsync_tick = 1'b0;
  endtask

  task automatic sweep_ball(input string nm);
    for (int i = 0; i < 8; i++) begin
      rd_addr = 3'(i);
      #1;
      chk(nm, rd_data, ball[i]);
    end
    rd_addr = 3'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] x [8] = '{8'h81, 8'h42, 8'h24, 8'h18, 8'h18, 8'h24, 8'h42, 8'h81};
    logic [7:0] w [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    tick();
    tick();
    chk("rst_busy", {7'd0, busy}, 8'd0);
    chk("rst_wr_ready", {7'd0, wr_ready}, 8'd1);
    chk("rst_err", {7'd0, err}, 8'd0);
    chk("rst_rd0", rd_data, 8'h3C);
    reset_n = 1'b1;
    started = 1'b1;
    tick();
    sweep_ball("reset_ball");

    // Early last on the 4th row.
    for (int i = 0; i < 3; i++) send(8'hA0 + 8'(i), 1'b0, 1'b0);
    chk("early_busy_mid", {7'd0, busy}, 8'd1);
    send(8'hA3, 1'b1, 1'b0);
    chk("early_err_pulse", {7'd0, err}, 8'd1);
    chk("early_idle", {7'd0, busy}, 8'd0);
    tick();
    chk("early_err_clear", {7'd0, err}, 8'd0);
    sweep_ball("early_active");

    // Eight rows with no last marker.
    for (int i = 0; i < 7; i++) send(8'hB0 + 8'(i), 1'b0, 1'b0);
    chk("miss_no_err_yet", {7'd0, err}, 8'd0);
    send(8'hB7, 1'b0, 1'b0);
    chk("miss_err_pulse", {7'd0, err}, 8'd1);
    chk("miss_idle", {7'd0, busy}, 8'd0);
    tick();
    chk("miss_err_clear", {7'd0, err}, 8'd0);
    sweep_ball("miss_active");

    // Normal load then vsync commit.
    for (int i = 0; i < 8; i++) send(x[i], i == 7, 1'b0);
    chk("load_pend_ready", {7'd0, wr_ready}, 8'd0);
    chk("load_pend_busy", {7'd0, busy}, 8'd1);
    rd_addr = 3'd3;
    tick();
    tick();
    chk("load_pre_commit", rd_data, 8'hFF);
    vsync();
    chk("load_post_commit", rd_data, 8'h18);
    chk("load_busy_low", {7'd0, busy}, 8'd0);
    rd_addr = 3'd0;
    #1;
    chk("load_row0", rd_data, 8'h81);

    // vsync coincident with the completing row must not commit.
    for (int i = 0; i < 8; i++) send(w[i], i == 7, i == 7);
    chk("coinc_no_commit", rd_data, 8'h81);
    wr_valid = 1'b1;
    wr_data = 8'hEE;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("coinc_ready_low", {7'd0, wr_ready}, 8'd0);
      chk("coinc_still_old", rd_data, 8'h81);
    end
    wr_valid = 1'b0;
    vsync();
    chk("coinc_commit", rd_data, 8'h01);
    rd_addr = 3'd7;
    #1;
    chk("coinc_row7", rd_data, 8'h80);

    // Reset in the middle of a load.
    for (int i = 0; i < 5; i++) send(8'hAA, 1'b0, 1'b0);
    reset_n = 1'b0;
    #1;
    chk("midrst_busy", {7'd0, busy}, 8'd0);
    chk("midrst_rd7", rd_data, 8'h3C);
    tick();
    reset_n = 1'b1;
    tick();
    sweep_ball("midrst_active");
    for (int i = 0; i < 8; i++) send(8'(i) * 8'h11, i == 7, 1'b0);
    vsync();
    rd_addr = 3'd2;
    #1;
    chk("after_rst_commit", rd_data, 8'h22);
    tick();
    tick();
    started = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
